cnt_obi_sampler: RTL and testbench

- OBI initiator (bus master) that samples a 32-bit word from a fixed source address and stores each sample to consecutive words of a destination buffer in memory.
- It drives the request side of the same OBI request/response types the counter peripheral responds to. Typical use: periodic snapshots of the counter value into SRAM without CPU involvement.
- Configured by plain ports from a host-side register block. Signals completion by a one-cycle pulse.

---
 rtl/cnt_obi_pkg.sv | 19 +
 rtl/cnt_obi_sampler_pkg.sv | 22 ++
 rtl/cnt_obi_sampler_timer.sv | 35 +++
 rtl/cnt_obi_sampler.sv | 196 +++++++++++++++++++
 tb/tb_cnt_obi_sampler.sv | 447 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cnt_obi_pkg.sv
// OBI request/response bundles shared by the counter peripheral and its initiators.
// Plain typedefs only; no logic.
package cnt_obi_pkg;

    typedef struct packed {
        logic        req;
        logic        we;
        logic [3:0]  be;
        logic [31:0] addr;
        logic [31:0] wdata;
    } obi_req_t;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
    } obi_resp_t;

endpackage

// File: rtl/cnt_obi_sampler_pkg.sv
// Shared types and constants for the OBI sampling initiator.
// FSM encoding, byte-enable and address stride for word transfers.
package cnt_obi_sampler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_GAP,
        ST_DONE
    } state_e;

    localparam logic [3:0]  BE_WORD     = 4'hF;
    localparam logic [31:0] ADDR_STRIDE = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cnt_obi_sampler_timer.sv
// Sampling-period counter: cleared on each new read request, saturates at max.
// Latency: expired_o is combinational from the registered count; no backpressure.
module cnt_obi_sampler_timer #(
    parameter int PER_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clr_i,
    input  logic [PER_W-1:0] period_i,
    output logic             expired_o
);

    logic [PER_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (cnt_q != {PER_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Look one cycle ahead so the next request lands exactly period_i cycles after the last.
    assign expired_o = ({1'b0, cnt_q} + {{PER_W{1'b0}}, 1'b1}) >= {1'b0, period_i};

endmodule

// File: rtl/cnt_obi_sampler.sv
// OBI initiator: reads a fixed source word len times and stores samples to a dst buffer.
// Latency: request visible the cycle after start_i; one outstanding transaction at a time.
// Backpressure: holds req/addr/wdata stable until gnt; optional CNT_OBI_SAMPLER_SUM_EN adds sum_o.
module cnt_obi_sampler
    import cnt_obi_pkg::*;
    import cnt_obi_sampler_pkg::*;
#(
    parameter int LEN_W = 16,
    parameter int PER_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [31:0]      src_addr_i,
    input  logic [31:0]      dst_addr_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic [PER_W-1:0] period_i,
    output obi_req_t         obi_req_o,
    input  obi_resp_t        obi_rsp_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [LEN_W-1:0] cnt_o
`ifdef CNT_OBI_SAMPLER_SUM_EN
    ,
    output logic [32+LEN_W-1:0] sum_o
`endif
);

    state_e           state_q;
    obi_req_t         req_q;
    logic             busy_q;
    logic             done_q;
    logic             abort_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] len_q;
    logic [31:0]      src_q;
    logic [31:0]      dst_q;
    logic [PER_W-1:0] period_q;
    logic [31:0]      sample_q;

    logic             abort_w;
    logic             expired_w;
    logic             start_ok_w;
    logic             enter_rd_w;
    logic             wr_done_w;
    logic [LEN_W-1:0] cnt_inc_w;

    function automatic obi_req_t mk_req(input logic we, input logic [31:0] addr,
                                        input logic [31:0] wdata);
        obi_req_t r;
        r.req   = 1'b1;
        r.we    = we;
        r.be    = BE_WORD;
        r.addr  = addr;
        r.wdata = wdata;
        return r;
    endfunction

    // A stop arriving in the same cycle as a decision point takes effect immediately.
    assign abort_w    = abort_q | stop_i;
    assign start_ok_w = (state_q == ST_IDLE) && start_i;
    assign enter_rd_w = (start_ok_w && (len_i != '0)) ||
                        ((state_q == ST_GAP) && !abort_w && expired_w);
    assign wr_done_w  = (state_q == ST_WR_WAIT) && obi_rsp_i.rvalid;
    assign cnt_inc_w  = cnt_q + 1'b1;

    cnt_obi_sampler_timer #(
        .PER_W (PER_W)
    ) u_timer (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clr_i     (enter_rd_w),
        .period_i  (period_q),
        .expired_o (expired_w)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            req_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            abort_q  <= 1'b0;
            cnt_q    <= '0;
            len_q    <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            period_q <= '0;
            sample_q <= '0;
        end else begin
            done_q <= 1'b0;
            if (busy_q && stop_i) begin
                abort_q <= 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        src_q    <= word_align(src_addr_i);
                        dst_q    <= word_align(dst_addr_i);
                        len_q    <= len_i;
                        period_q <= period_i;
                        cnt_q    <= '0;
                        busy_q   <= 1'b1;
                        abort_q  <= 1'b0;
                        if (len_i == '0) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_RD_REQ;
                            req_q   <= mk_req(1'b0, word_align(src_addr_i), '0);
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (obi_rsp_i.gnt) begin
                        state_q   <= ST_RD_WAIT;
                        req_q.req <= 1'b0;
                    end
                end
                ST_RD_WAIT: begin
                    if (obi_rsp_i.rvalid) begin
                        sample_q <= obi_rsp_i.rdata;
                        if (abort_w) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_WR_REQ;
                            req_q   <= mk_req(1'b1, dst_q + ADDR_STRIDE * 32'(cnt_q),
                                              obi_rsp_i.rdata);
                        end
                    end
                end
                ST_WR_REQ: begin
                    if (obi_rsp_i.gnt) begin
                        state_q   <= ST_WR_WAIT;
                        req_q.req <= 1'b0;
                    end
                end
                ST_WR_WAIT: begin
                    if (obi_rsp_i.rvalid) begin
                        cnt_q <= cnt_inc_w;
                        if ((cnt_inc_w == len_q) || abort_w) begin
                            state_q <= ST_DONE;
                        end else begin
                            state_q <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (abort_w) begin
                        state_q <= ST_DONE;
                    end else if (expired_w) begin
                        state_q <= ST_RD_REQ;
                        req_q   <= mk_req(1'b0, src_q, '0);
                    end
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CNT_OBI_SAMPLER_SUM_EN
    logic [32+LEN_W-1:0] sum_q, sum_d;

    always_comb begin
        sum_d = sum_q;
        if (start_ok_w) begin
            sum_d = '0;
        end else if (wr_done_w) begin
            sum_d = sum_q + (32+LEN_W)'(sample_q);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sum_q <= '0;
        end else begin
            sum_q <= sum_d;
        end
    end

    assign sum_o = sum_q;
`endif

    assign obi_req_o = req_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign cnt_o     = cnt_q;

endmodule

// File: tb/tb_cnt_obi_sampler.sv
// Bench for cnt_obi_sampler: behavioural OBI responder plus a transaction scoreboard.
module tb_cnt_obi_sampler;
    import cnt_obi_pkg::*;

    localparam int LEN_W = 16;
    localparam int PER_W = 32;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic             stop = 1'b0;
    logic [31:0]      src = '0;
    logic [31:0]      dst = '0;
    logic [LEN_W-1:0] len = '0;
    logic [PER_W-1:0] period = '0;
    obi_req_t         req;
    obi_resp_t        rsp;
    logic             busy, done;
    logic [LEN_W-1:0] cnt;
`ifdef CNT_OBI_SAMPLER_SUM_EN
    logic [32+LEN_W-1:0] sum;
`endif

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    txn_t        obs_q[$];
    logic [31:0] rd_data_q[$];
    int          rd_cyc_q[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          gnt_dly = 0;
    int          rv_dly = 0;
    int          unstable = 0;
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          req_cycles = 0;
    int          start_cyc = 0;

    always #5 clk = ~clk;

    cnt_obi_sampler #(
        .LEN_W (LEN_W),
        .PER_W (PER_W)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .start_i    (start),
        .stop_i     (stop),
        .src_addr_i (src),
        .dst_addr_i (dst),
        .len_i      (len),
        .period_i   (period),
        .obi_req_o  (req),
        .obi_rsp_i  (rsp),
        .busy_o     (busy),
        .done_o     (done),
        .cnt_o      (cnt)
`ifdef CNT_OBI_SAMPLER_SUM_EN
        ,
        .sum_o      (sum)
`endif
    );

    // Responder: grants after gnt_dly waiting cycles, answers rv_dly cycles after the cycle following gnt.
    initial begin
        bit       rv_pend = 0;
        bit       hold_vld = 0;
        int       rv_c = 0;
        int       wait_c = 0;
        obi_req_t hold;
        txn_t     t;
        rsp = '0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            rsp.gnt = 1'b0;
            rsp.rvalid = 1'b0;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (req.req) req_cycles++;
            if (rst) begin
                rv_pend = 0;
                hold_vld = 0;
                wait_c = 0;
            end else if (rv_pend) begin
                if (rv_c == 0) begin
                    rsp.rvalid = 1'b1;
                    rsp.rdata = (rd_data_q.size() > 0) ? rd_data_q.pop_front() : 32'hBAD0_0000;
                    rv_pend = 0;
                end else begin
                    rv_c--;
                end
            end else if (req.req) begin
                if (!hold_vld) begin
                    hold = req;
                    hold_vld = 1;
                    if (!req.we) rd_cyc_q.push_back(cyc);
                end else if (req !== hold) begin
                    unstable++;
                end
                if (wait_c >= gnt_dly) begin
                    rsp.gnt = 1'b1;
                    wait_c = 0;
                    hold_vld = 0;
                    t.we = req.we;
                    t.addr = req.addr;
                    t.data = req.wdata;
                    obs_q.push_back(t);
                    rv_pend = 1;
                    rv_c = rv_dly;
                    // Reads consume rdata at rvalid; writes get an ignored pattern.
                    if (req.we) rd_data_q.push_front(32'hBAD0_0000);
                end else begin
                    wait_c++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void push_exp(input logic we, input logic [31:0] addr, input logic [31:0] data);
        txn_t t;
        t.we = we;
        t.addr = addr;
        t.data = data;
        exp_q.push_back(t);
    endfunction

    task automatic kick(input logic [31:0] s, input logic [31:0] d, input int l, input int p);
        obs_q.delete();
        rd_cyc_q.delete();
        done_cnt = 0;
        req_cycles = 0;
        unstable = 0;
        @(negedge clk);
        src = s;
        dst = d;
        len = LEN_W'(l);
        period = PER_W'(p);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done_cnt > 0) begin
                ok = 1;
                break;
            end
        end
        repeat (6) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (req !== '0 || busy !== 1'b0 || done !== 1'b0 || cnt !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%h busy=%b done=%b cnt=%0d, want all zero", req, busy, done, cnt);
        end
`ifdef CNT_OBI_SAMPLER_SUM_EN
        checks++;
        if (sum !== '0) begin
            errors++;
            $display("FAIL reset_sum: got %h want 0", sum);
        end
`endif
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        bit ok;
        txn_t e, o;
        gnt_dly = 0;
        rv_dly = 0;
        rd_data_q = '{32'h5, 32'h6, 32'h7};
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            push_exp(1'b0, 32'h2000_0000, 32'h0);
            push_exp(1'b1, 32'h0000_1000 + 32'(4 * i), 32'(5 + i));
        end
        kick(32'h2000_0000, 32'h0000_1000, 3, 0);
        wait_done(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_timeout: done_o never pulsed"); end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL basic_txn_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.we !== e.we || o.addr !== e.addr || (e.we && o.data !== e.data)) begin
                errors++;
                $display("FAIL basic_txn: got we=%b addr=%h data=%h want we=%b addr=%h data=%h", o.we, o.addr, o.data, e.we, e.addr, e.data);
            end
        end
        checks++;
        if (cnt !== 16'd3 || done_cnt !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_status: got cnt=%0d pulses=%0d busy=%b want cnt=3 pulses=1 busy=0", cnt, done_cnt, busy);
        end
        checks++;
        if (rd_cyc_q.size() == 0 || rd_cyc_q[0] !== start_cyc + 1) begin
            errors++;
            $display("FAIL basic_first_req: got cycle %0d want %0d", (rd_cyc_q.size() > 0) ? rd_cyc_q[0] : -1, start_cyc + 1);
        end
`ifdef CNT_OBI_SAMPLER_SUM_EN
        checks++;
        if (sum !== 48'd18) begin errors++; $display("FAIL basic_sum: got %h want 12", sum); end
`endif
    endtask

    task automatic test_wait_states;
        bit ok;
        txn_t e, o;
        gnt_dly = 3;
        rv_dly = 2;
        rd_data_q = '{32'h5, 32'h6, 32'h7};
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            push_exp(1'b0, 32'h2000_0000, 32'h0);
            push_exp(1'b1, 32'h0000_1000 + 32'(4 * i), 32'(5 + i));
        end
        // Low address bits must be ignored.
        kick(32'h2000_0003, 32'h0000_1002, 3, 0);
        wait_done(400, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL wait_timeout: done_o never pulsed"); end
        checks++;
        if (unstable !== 0) begin errors++; $display("FAIL wait_stable: got %0d changes while waiting for gnt, want 0", unstable); end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL wait_txn_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.we !== e.we || o.addr !== e.addr || (e.we && o.data !== e.data)) begin
                errors++;
                $display("FAIL wait_txn: got we=%b addr=%h data=%h want we=%b addr=%h data=%h", o.we, o.addr, o.data, e.we, e.addr, e.data);
            end
        end
        checks++;
        if (cnt !== 16'd3 || done_cnt !== 1) begin
            errors++;
            $display("FAIL wait_status: got cnt=%0d pulses=%0d want cnt=3 pulses=1", cnt, done_cnt);
        end
    endtask

    task automatic test_period;
        bit ok;
        int gap;
        txn_t e, o;
        gnt_dly = 0;
        rv_dly = 0;
        rd_data_q = '{32'h11, 32'h22};
        exp_q.delete();
        // Destination wraps past the top of the address space.
        push_exp(1'b0, 32'h2000_0000, 32'h0);
        push_exp(1'b1, 32'hFFFF_FFFC, 32'h11);
        push_exp(1'b0, 32'h2000_0000, 32'h0);
        push_exp(1'b1, 32'h0000_0000, 32'h22);
        kick(32'h2000_0000, 32'hFFFF_FFFC, 2, 10);
        wait_done(200, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL period_timeout: done_o never pulsed"); end
        gap = (rd_cyc_q.size() >= 2) ? rd_cyc_q[1] - rd_cyc_q[0] : -1;
        checks++;
        if (gap !== 10) begin errors++; $display("FAIL period_gap: got %0d cycles want 10", gap); end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL period_txn_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.we !== e.we || o.addr !== e.addr || (e.we && o.data !== e.data)) begin
                errors++;
                $display("FAIL period_txn: got we=%b addr=%h data=%h want we=%b addr=%h data=%h", o.we, o.addr, o.data, e.we, e.addr, e.data);
            end
        end
    endtask

    task automatic test_len0;
        bit ok;
        kick(32'h2000_0000, 32'h0000_1000, 0, 0);
        wait_done(50, ok);
        checks++;
        if (!ok || done_cyc - start_cyc !== 2 || done_cnt !== 1) begin
            errors++;
            $display("FAIL len0_done: got delay=%0d pulses=%0d want delay=2 pulses=1", done_cyc - start_cyc, done_cnt);
        end
        checks++;
        if (req_cycles !== 0 || cnt !== '0) begin
            errors++;
            $display("FAIL len0_noreq: got req_cycles=%0d cnt=%0d want 0 and 0", req_cycles, cnt);
        end
    endtask

    task automatic test_stop;
        bit ok;
        txn_t e, o;
        gnt_dly = 0;
        rv_dly = 2;
        rd_data_q = '{32'hA1, 32'hA2};
        exp_q.delete();
        push_exp(1'b0, 32'h2000_0000, 32'h0);
        push_exp(1'b1, 32'h0000_3000, 32'hA1);
        push_exp(1'b0, 32'h2000_0000, 32'h0);
        kick(32'h2000_0000, 32'h0000_3000, 5, 0);
        for (int i = 0; i < 100; i++) begin
            if (rd_cyc_q.size() == 1 && !req.req) break;
            @(negedge clk);
        end
        src = 32'h9999_0000;
        len = 16'd1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (rd_cyc_q.size() == 2 && !req.req) break;
            @(negedge clk);
        end
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        wait_done(100, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL stop_timeout: done_o never pulsed"); end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL stop_txn_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.we !== e.we || o.addr !== e.addr || (e.we && o.data !== e.data)) begin
                errors++;
                $display("FAIL stop_txn: got we=%b addr=%h data=%h want we=%b addr=%h data=%h", o.we, o.addr, o.data, e.we, e.addr, e.data);
            end
        end
        checks++;
        if (cnt !== 16'd1 || done_cnt !== 1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL stop_status: got cnt=%0d pulses=%0d busy=%b want cnt=1 pulses=1 busy=0", cnt, done_cnt, busy);
        end
        rd_data_q.delete();
    endtask

    task automatic test_reset_mid;
        bit ok;
        txn_t e, o;
        gnt_dly = 3;
        rv_dly = 0;
        rd_data_q = '{32'h1, 32'h2, 32'h3};
        kick(32'h2000_0000, 32'h0000_1000, 3, 0);
        for (int i = 0; i < 100; i++) begin
            if (req.req && req.we) break;
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (req !== '0 || busy !== 1'b0 || done !== 1'b0 || cnt !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got req=%h busy=%b done=%b cnt=%0d, want all zero", req, busy, done, cnt);
        end
        rst = 1'b0;
        @(negedge clk);
        gnt_dly = 1;
        rd_data_q = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        exp_q.delete();
        for (int i = 0; i < 3; i++) begin
            push_exp(1'b0, 32'h4000_0000, 32'h0);
            push_exp(1'b1, 32'h0000_2000 + 32'(4 * i), 32'hFFFF_FFFF);
        end
        kick(32'h4000_0000, 32'h0000_2000, 3, 0);
        wait_done(300, ok);
        checks++;
        if (!ok) begin errors++; $display("FAIL rerun_timeout: done_o never pulsed"); end
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++;
            $display("FAIL rerun_txn_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o.we !== e.we || o.addr !== e.addr || (e.we && o.data !== e.data)) begin
                errors++;
                $display("FAIL rerun_txn: got we=%b addr=%h data=%h want we=%b addr=%h data=%h", o.we, o.addr, o.data, e.we, e.addr, e.data);
            end
        end
        checks++;
        if (cnt !== 16'd3 || done_cnt !== 1) begin
            errors++;
            $display("FAIL rerun_status: got cnt=%0d pulses=%0d want cnt=3 pulses=1", cnt, done_cnt);
        end
`ifdef CNT_OBI_SAMPLER_SUM_EN
        checks++;
        if (sum !== 48'h2_FFFF_FFFD) begin errors++; $display("FAIL rerun_sum: got %h want 2fffffffd", sum); end
`endif
    endtask

    initial begin
        test_reset;
        test_basic;
        test_wait_states;
        test_period;
        test_len0;
        test_stop;
        test_reset_mid;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
